// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage pipeline control logic.
package pipeline_pkg;

    localparam logic [1:0] FWD_RF      = 2'd0;
    localparam logic [1:0] FWD_RESULTW = 2'd1;
    localparam logic [1:0] FWD_ALUOUTM = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE,
        MEM_WAIT
    } state_t;

    // True when a write to dst by a later stage supplies src; register 0 is hardwired and never matches.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst, input logic we);
        return we && (src != REG_ZERO) && (src == dst);
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational operand-forwarding selects for the D-stage compare and the E-stage ALU.
module forward_unit
    import pipeline_pkg::*;
(
    input  logic [4:0] rsd,
    input  logic [4:0] rtd,
    input  logic [4:0] rse,
    input  logic [4:0] rte,
    input  logic [4:0] writeregm,
    input  logic [4:0] writeregw,
    input  logic       regwritem,
    input  logic       regwritew,
    output logic       forwardad,
    output logic       forwardbd,
    output logic [1:0] forwardae,
    output logic [1:0] forwardbe
);

    // The M-stage result is younger than W, so it wins when both match.
    always_comb begin
        forwardae = FWD_RF;
        forwardbe = FWD_RF;
        if (reg_match(rse, writeregm, regwritem)) begin
            forwardae = FWD_ALUOUTM;
        end else if (reg_match(rse, writeregw, regwritew)) begin
            forwardae = FWD_RESULTW;
        end
        if (reg_match(rte, writeregm, regwritem)) begin
            forwardbe = FWD_ALUOUTM;
        end else if (reg_match(rte, writeregw, regwritew)) begin
            forwardbe = FWD_RESULTW;
        end
    end

    assign forwardad = reg_match(rsd, writeregm, regwritem);
    assign forwardbd = reg_match(rtd, writeregm, regwritem);

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/forward generation, memory-wait sequencing and stall statistics for the pipeline.
module hazard_controller
    import pipeline_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rsd,
    input  logic [4:0]       rtd,
    input  logic [4:0]       rse,
    input  logic [4:0]       rte,
    input  logic [4:0]       writerege,
    input  logic [4:0]       writeregm,
    input  logic [4:0]       writeregw,
    input  logic             regwritee,
    input  logic             regwritem,
    input  logic             regwritew,
    input  logic             memtorege,
    input  logic             memtoregm,
    input  logic             memwritem,
    input  logic             branchd,
    input  logic             memready,
    output logic             stallf,
    output logic             stalld,
    output logic             stalle,
    output logic             stallm,
    output logic             stallw,
    output logic             flushe,
    output logic             forwardad,
    output logic             forwardbd,
    output logic [1:0]       forwardae,
    output logic [1:0]       forwardbe,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             mem_timeout
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t            state;
    state_t            next_state;
    logic [WAIT_W-1:0] waitcnt;
    logic [WAIT_W-1:0] next_waitcnt;
    logic              memacc;
    logic              memstall;
    logic              lwstall;
    logic              brstall;
    logic              fwd_ad;
    logic              fwd_bd;
    logic [1:0]        fwd_ae;
    logic [1:0]        fwd_be;

    forward_unit u_forward_unit (
        .rsd       (rsd),
        .rtd       (rtd),
        .rse       (rse),
        .rte       (rte),
        .writeregm (writeregm),
        .writeregw (writeregw),
        .regwritem (regwritem),
        .regwritew (regwritew),
        .forwardad (fwd_ad),
        .forwardbd (fwd_bd),
        .forwardae (fwd_ae),
        .forwardbe (fwd_be)
    );

    assign memacc  = memtoregm || memwritem;
    assign lwstall = memtorege && ((rte == rsd) || (rte == rtd));
    assign brstall = branchd &&
                     ((regwritee && (writerege != REG_ZERO) &&
                       ((writerege == rsd) || (writerege == rtd))) ||
                      (memtoregm && (writeregm != REG_ZERO) &&
                       ((writeregm == rsd) || (writeregm == rtd))));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            waitcnt      <= '0;
            stall_cycles <= '0;
            mem_timeout  <= 1'b0;
        end else begin
            state   <= next_state;
            waitcnt <= next_waitcnt;
            if (stallf && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if ((state == MEM_WAIT) && (waitcnt >= WAIT_W'(TIMEOUT))) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    // The first missed cycle already stalls, so waitcnt starts at 1 on entry to MEM_WAIT.
    always_comb begin
        next_state   = state;
        next_waitcnt = waitcnt;
        memstall     = 1'b0;
        case (state)
            IDLE: begin
                if (memacc && !memready) begin
                    memstall     = 1'b1;
                    next_state   = MEM_WAIT;
                    next_waitcnt = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!memready) begin
                    memstall = 1'b1;
                    if (waitcnt != {WAIT_W{1'b1}}) begin
                        next_waitcnt = waitcnt + WAIT_W'(1);
                    end
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // A memory freeze holds every stage, so no bubble may be injected while it lasts.
    always_comb begin
        stallf    = 1'b0;
        stalld    = 1'b0;
        stalle    = 1'b0;
        stallm    = 1'b0;
        stallw    = 1'b0;
        flushe    = 1'b0;
        forwardad = 1'b0;
        forwardbd = 1'b0;
        forwardae = FWD_RF;
        forwardbe = FWD_RF;
        if (reset) begin
            flushe = 1'b1;
        end else begin
            forwardad = fwd_ad;
            forwardbd = fwd_bd;
            forwardae = fwd_ae;
            forwardbe = fwd_be;
            if (memstall) begin
                stallf = 1'b1;
                stalld = 1'b1;
                stalle = 1'b1;
                stallm = 1'b1;
                stallw = 1'b1;
            end else if (lwstall || brstall) begin
                stallf = 1'b1;
                stalld = 1'b1;
                flushe = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: a reference model queues expectations, a negedge monitor checks them.
module tb_hazard_controller;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       rsd, rtd, rse, rte;
    logic [4:0]       writerege, writeregm, writeregw;
    logic             regwritee, regwritem, regwritew;
    logic             memtorege, memtoregm, memwritem;
    logic             branchd, memready;
    logic             stallf, stalld, stalle, stallm, stallw, flushe;
    logic             forwardad, forwardbd;
    logic [1:0]       forwardae, forwardbe;
    logic [CNT_W-1:0] stall_cycles;
    logic             mem_timeout;

    typedef struct {
        string      tag;
        logic [4:0] stalls;
        logic       flushe;
        logic       fad;
        logic       fbd;
        logic [1:0] fae;
        logic [1:0] fbe;
        int         cycles;
        logic       timeout;
    } exp_t;

    exp_t exp_q[$];

    int compare_count  = 0;
    int mismatch_count = 0;

    logic m_wait  = 1'b0;
    int   m_wlen  = 0;
    logic m_to    = 1'b0;
    int   m_cnt   = 0;

    hazard_controller #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .rsd          (rsd),
        .rtd          (rtd),
        .rse          (rse),
        .rte          (rte),
        .writerege    (writerege),
        .writeregm    (writeregm),
        .writeregw    (writeregw),
        .regwritee    (regwritee),
        .regwritem    (regwritem),
        .regwritew    (regwritew),
        .memtorege    (memtorege),
        .memtoregm    (memtoregm),
        .memwritem    (memwritem),
        .branchd      (branchd),
        .memready     (memready),
        .stallf       (stallf),
        .stalld       (stalld),
        .stalle       (stalle),
        .stallm       (stallm),
        .stallw       (stallw),
        .flushe       (flushe),
        .forwardad    (forwardad),
        .forwardbd    (forwardbd),
        .forwardae    (forwardae),
        .forwardbe    (forwardbe),
        .stall_cycles (stall_cycles),
        .mem_timeout  (mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [1:0] modelFwdE(input logic [4:0] src);
        if (src == 5'd0) return 2'd0;
        if (regwritem && writeregm == src) return 2'd2;
        if (regwritew && writeregw == src) return 2'd1;
        return 2'd0;
    endfunction

    task automatic clearInputs();
        rsd = 0; rtd = 0; rse = 0; rte = 0;
        writerege = 0; writeregm = 0; writeregw = 0;
        regwritee = 0; regwritem = 0; regwritew = 0;
        memtorege = 0; memtoregm = 0; memwritem = 0;
        branchd = 0; memready = 1'b1;
    endtask

    // Predict this cycle's outputs from the current inputs, queue them, then advance the model one edge.
    task automatic applyStimulus(input string tag);
        exp_t e;
        logic mst, lw, br;
        mst = !reset && !memready && (m_wait || memtoregm || memwritem);
        lw  = memtorege && (rte == rsd || rte == rtd);
        br  = branchd && ((regwritee && writerege != 0 && (writerege == rsd || writerege == rtd)) ||
                          (memtoregm && writeregm != 0 && (writeregm == rsd || writeregm == rtd)));
        e.tag     = tag;
        e.cycles  = m_cnt;
        e.timeout = m_to;
        if (reset) begin
            e.stalls = 5'b00000; e.flushe = 1'b1;
            e.fad = 0; e.fbd = 0; e.fae = 0; e.fbe = 0;
        end else begin
            e.fad = (rsd != 0) && regwritem && (writeregm == rsd);
            e.fbd = (rtd != 0) && regwritem && (writeregm == rtd);
            e.fae = modelFwdE(rse);
            e.fbe = modelFwdE(rte);
            if (mst) begin
                e.stalls = 5'b11111; e.flushe = 1'b0;
            end else if (lw || br) begin
                e.stalls = 5'b11000; e.flushe = 1'b1;
            end else begin
                e.stalls = 5'b00000; e.flushe = 1'b0;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        if (reset) begin
            m_wait = 0; m_wlen = 0; m_to = 0; m_cnt = 0;
        end else begin
            if (m_wait && m_wlen >= TIMEOUT) m_to = 1'b1;
            if (e.stalls[4] && m_cnt < CNT_MAX) m_cnt++;
            m_wlen = mst ? (m_wait ? m_wlen + 1 : 1) : 0;
            m_wait = mst;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput({e.tag, ".stalls"}, 32'({stallf, stalld, stalle, stallm, stallw}), 32'(e.stalls));
            checkOutput({e.tag, ".flushe"}, 32'(flushe), 32'(e.flushe));
            checkOutput({e.tag, ".fwd_d"}, 32'({forwardad, forwardbd}), 32'({e.fad, e.fbd}));
            checkOutput({e.tag, ".fwd_e"}, 32'({forwardae, forwardbe}), 32'({e.fae, e.fbe}));
            checkOutput({e.tag, ".stall_cycles"}, 32'(stall_cycles), 32'(e.cycles));
            checkOutput({e.tag, ".mem_timeout"}, 32'(mem_timeout), 32'(e.timeout));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearInputs();
        reset = 1'b1;
        rse = 5; regwritem = 1; writeregm = 5; memtoregm = 1; memready = 0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus("reset_hold");

        clearInputs(); reset = 1'b0;
        applyStimulus("idle");

        rse = 5; rsd = 5; regwritem = 1; writeregm = 5; regwritew = 1; writeregw = 5;
        applyStimulus("fwd_m_priority");
        writeregm = 6;
        applyStimulus("fwd_w");
        clearInputs(); regwritem = 1; regwritew = 1;
        applyStimulus("fwd_reg0");
        clearInputs(); rte = 9; rtd = 9; regwritem = 1; writeregm = 9; regwritew = 1; writeregw = 9;
        applyStimulus("fwd_b");

        clearInputs(); memtorege = 1; rte = 7; rsd = 7;
        applyStimulus("loaduse");
        clearInputs();
        applyStimulus("after_loaduse");

        branchd = 1; rsd = 3; regwritee = 1; writerege = 3;
        applyStimulus("branch_e");
        clearInputs(); branchd = 1; rsd = 3; regwritem = 1; writeregm = 3;
        applyStimulus("branch_fwd");
        clearInputs(); branchd = 1; rtd = 4; memtoregm = 1; writeregm = 4; memready = 1;
        applyStimulus("branch_load_m_ready");
        clearInputs(); branchd = 1; regwritee = 1;
        applyStimulus("branch_reg0");

        clearInputs(); reset = 1'b1;
        applyStimulus("reset2");
        reset = 1'b0;
        memtoregm = 1; memready = 0;
        applyStimulus("mw1_wait");
        memready = 1;
        applyStimulus("mw1_release");
        clearInputs();
        applyStimulus("mw1_after");

        memtoregm = 1; memready = 0;
        for (int i = 0; i < 3; i++) applyStimulus("mw3_wait");
        memready = 1;
        applyStimulus("mw3_release");
        clearInputs();
        for (int i = 0; i < 2; i++) applyStimulus("timeout_sticky");

        memtoregm = 1; memready = 0;
        applyStimulus("rst_mid_a");
        applyStimulus("rst_mid_b");
        reset = 1'b1;
        applyStimulus("rst_mid_reset");
        clearInputs(); reset = 1'b0; memready = 0;
        applyStimulus("rst_mid_after");

        memtorege = 1; rte = 7; rsd = 7; memtoregm = 1; memready = 0;
        applyStimulus("lw_mem_a");
        applyStimulus("lw_mem_b");
        memready = 1;
        applyStimulus("lw_mem_release");
        clearInputs();
        applyStimulus("lw_mem_after");

        memwritem = 1; memready = 0;
        for (int i = 0; i < 16; i++) applyStimulus("store_wait_saturate");
        memready = 1;
        applyStimulus("store_release");

        for (int i = 0; i < 60; i++) begin
            reset     = ($urandom_range(0, 15) == 0);
            rsd       = 5'($urandom_range(0, 3));
            rtd       = 5'($urandom_range(0, 3));
            rse       = 5'($urandom_range(0, 3));
            rte       = 5'($urandom_range(0, 3));
            writerege = 5'($urandom_range(0, 3));
            writeregm = 5'($urandom_range(0, 3));
            writeregw = 5'($urandom_range(0, 3));
            regwritee = 1'($urandom_range(0, 1));
            regwritem = 1'($urandom_range(0, 1));
            regwritew = 1'($urandom_range(0, 1));
            memtorege = 1'($urandom_range(0, 1));
            memtoregm = 1'($urandom_range(0, 1));
            memwritem = 1'($urandom_range(0, 1));
            branchd   = 1'($urandom_range(0, 1));
            memready  = ($urandom_range(0, 2) != 0);
            applyStimulus("random");
        end

        @(negedge clk);
        #1;
        checkOutput("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
